xgmii_tx_arbiter: RTL and testbench

//  Shares one 64-bit XGMII TX path (clk156 domain, feeding network_path xgmii_txd/txc) among N frame sources.

---
 rtl/xgmii_tx_arbiter_pkg.sv | 27 ++
 rtl/xgmii_tx_arbiter_rr_pick.sv | 38 +++
 rtl/xgmii_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_xgmii_tx_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_tx_arbiter_pkg.sv
// ============================================================================
// xgmii_tx_arbiter_pkg
// Shared XGMII column constants and the arbiter state encoding.
// Imported by the TX arbiter top and its round-robin picker.
// ============================================================================
package xgmii_tx_arbiter_pkg;

    // Idle column: /I/ in every lane, all lanes flagged as control
    localparam logic [63:0] XGMII_IDLE_D = {8{8'h07}};
    localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;

    // Error column: /E/ in every lane, used to poison a killed frame
    localparam logic [63:0] XGMII_ERR_D  = {8{8'hFE}};
    localparam logic [7:0]  XGMII_ERR_C  = 8'hFF;

    // Frame delimiters, kept here for the sources and the RX side
    localparam logic [7:0]  XGMII_START  = 8'hFB;
    localparam logic [7:0]  XGMII_TERM   = 8'hFD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP,
        ST_DRAIN
    } arb_state_t;

endpackage

// File: rtl/xgmii_tx_arbiter_rr_pick.sv
// ============================================================================
// rr_pick
// Combinational round-robin picker: returns the first set request at or after
// the pointer, wrapping around. Shared between the TX and RX arbiters.
// Ports:
//   req_masked  in  N_REQ  eligible requests
//   ptr         in  PW     index searched first
//   valid       out 1      at least one eligible request
//   winner      out PW     index of the chosen request
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_masked,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    winner
);

    logic [PW-1:0] idx;

    // Walk the requests starting at ptr; the first hit wins and later hits
    // are ignored so the result is the nearest requester in rotation order.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!valid && req_masked[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_arbiter.sv
// ============================================================================
// xgmii_tx_arbiter
// Shares one 64-bit XGMII TX path among N_REQ frame sources. Grants change
// only at frame boundaries, in round-robin order, with an idle gap after each
// frame. A watchdog or link loss kills the current frame with an error column.
// Ports:
//   xgmii_clk  in   1         sole clock (156.25 MHz)
//   sys_rst    in   1         synchronous active-high reset
//   link_up    in   1         low => no grants, idle output
//   req        in   N_REQ     per-source request, high for the whole frame
//   src_txd    in   N_REQ*64  per-source data, source i at [64*i +: 64]
//   src_txc    in   N_REQ*8   per-source control, source i at [8*i +: 8]
//   grant      out  N_REQ     one-hot or zero grant
//   xgmii_txd  out  64        arbitrated data
//   xgmii_txc  out  8         arbitrated control
//   busy       out  1         high while a grant is held
//   abort      out  1         one-cycle pulse when a frame is killed
// ============================================================================
module xgmii_tx_arbiter
    import xgmii_tx_arbiter_pkg::*;
#(
    parameter int N_REQ            = 2,
    parameter int IFG_CYCLES       = 2,
    parameter int MAX_FRAME_CYCLES = 1200
) (
    input  logic                 xgmii_clk,
    input  logic                 sys_rst,
    input  logic                 link_up,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*64-1:0]  src_txd,
    input  logic [N_REQ*8-1:0]   src_txc,
    output logic [N_REQ-1:0]     grant,
    output logic [63:0]          xgmii_txd,
    output logic [7:0]           xgmii_txc,
    output logic                 busy,
    output logic                 abort
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FCW = $clog2(MAX_FRAME_CYCLES + 1);
    localparam int GCW = $clog2(IFG_CYCLES + 1);

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    cur;
    logic [N_REQ-1:0] mask;
    logic [FCW-1:0]   frame_cnt;
    logic [GCW-1:0]   gap_cnt;

    logic [N_REQ-1:0] req_masked;
    logic             pick_valid;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    next_ptr;
    logic [63:0]      cur_txd;
    logic [7:0]       cur_txc;

    // A source killed by an abort stays masked until it drops its request,
    // so a stuck source cannot immediately win the link back.
    assign req_masked = req & ~mask;
    assign next_ptr   = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
    assign cur_txd    = src_txd[64*cur +: 64];
    assign cur_txc    = src_txc[8*cur +: 8];

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req_masked (req_masked),
        .ptr        (ptr),
        .valid      (pick_valid),
        .winner     (winner)
    );

    // Arbiter FSM with registered grant and output column. Frame end (req
    // dropped) is tested before the watchdog so a frame that ends exactly on
    // the limit finishes normally. Both endings enter the same idle gap.
    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cur       <= '0;
            mask      <= '0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            grant     <= '0;
            xgmii_txd <= XGMII_IDLE_D;
            xgmii_txc <= XGMII_IDLE_C;
            busy      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            mask  <= mask & req;

            case (state)
                ST_IDLE: begin
                    xgmii_txd <= XGMII_IDLE_D;
                    xgmii_txc <= XGMII_IDLE_C;
                    if (link_up && pick_valid) begin
                        cur           <= winner;
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        busy          <= 1'b1;
                        ptr           <= next_ptr;
                        frame_cnt     <= '0;
                        state         <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (!req[cur]) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        xgmii_txd <= XGMII_IDLE_D;
                        xgmii_txc <= XGMII_IDLE_C;
                        gap_cnt   <= GCW'(IFG_CYCLES - 1);
                        state     <= ST_GAP;
                    end else if ((frame_cnt == FCW'(MAX_FRAME_CYCLES - 1)) || !link_up) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        xgmii_txd <= XGMII_ERR_D;
                        xgmii_txc <= XGMII_ERR_C;
                        abort     <= 1'b1;
                        mask[cur] <= 1'b1;
                        gap_cnt   <= GCW'(IFG_CYCLES - 1);
                        state     <= ST_GAP;
                    end else begin
                        xgmii_txd <= cur_txd;
                        xgmii_txc <= cur_txc;
                        frame_cnt <= frame_cnt + FCW'(1);
                    end
                end

                ST_GAP, ST_DRAIN: begin
                    xgmii_txd <= XGMII_IDLE_D;
                    xgmii_txc <= XGMII_IDLE_C;
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GCW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// ============================================================================
// tb_xgmii_tx_arbiter
// Self-checking bench for xgmii_tx_arbiter (N_REQ=2, IFG_CYCLES=2,
// MAX_FRAME_CYCLES=16). A reference model pushes the expected output column
// for every clock edge into a scoreboard; each scenario task pops and compares
// it on the falling edge and adds its own scenario-specific checks.
// ============================================================================
module tb_xgmii_tx_arbiter;

    localparam int N_REQ            = 2;
    localparam int IFG_CYCLES       = 2;
    localparam int MAX_FRAME_CYCLES = 16;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;

    logic         xgmii_clk = 1'b0;
    logic         sys_rst   = 1'b1;
    logic         link_up   = 1'b1;
    logic [1:0]   req       = 2'b00;
    logic [127:0] src_txd   = '0;
    logic [15:0]  src_txc   = '0;
    logic [1:0]   grant;
    logic [63:0]  xgmii_txd;
    logic [7:0]   xgmii_txc;
    logic         busy;
    logic         abort;

    typedef struct packed {
        logic [1:0]  grant;
        logic        busy;
        logic        abort;
        logic [7:0]  txc;
        logic [63:0] txd;
    } obs_t;

    obs_t sb[$];
    obs_t exp_o;
    obs_t obs;

    int total_checks  = 0;
    int passed_checks = 0;

    assign obs = {grant, busy, abort, xgmii_txc, xgmii_txd};

    xgmii_tx_arbiter #(
        .N_REQ            (N_REQ),
        .IFG_CYCLES       (IFG_CYCLES),
        .MAX_FRAME_CYCLES (MAX_FRAME_CYCLES)
    ) dut (
        .xgmii_clk (xgmii_clk),
        .sys_rst   (sys_rst),
        .link_up   (link_up),
        .req       (req),
        .src_txd   (src_txd),
        .src_txc   (src_txc),
        .grant     (grant),
        .xgmii_txd (xgmii_txd),
        .xgmii_txc (xgmii_txc),
        .busy      (busy),
        .abort     (abort)
    );

    // 156.25 MHz is approximated by a 6-unit period
    always #3 xgmii_clk = ~xgmii_clk;

    // ------------------------------------------------------------------
    // Reference model: evaluates the arbitration rules on each rising edge
    // and queues the column the DUT should present after that edge.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_GRANT, M_GAP} mstate_t;
    mstate_t     m_state;
    int          m_ptr, m_cur, m_fcnt, m_gcnt, m_idx;
    logic        m_found, m_kill;
    logic [1:0]  m_mask, m_grant;
    logic [63:0] m_txd;
    logic [7:0]  m_txc;
    logic        m_busy, m_abort;

    initial begin : ref_model
        forever begin
            @(posedge xgmii_clk);
            if (sys_rst) begin
                m_state = M_IDLE;
                m_ptr   = 0;
                m_cur   = 0;
                m_fcnt  = 0;
                m_gcnt  = 0;
                m_mask  = '0;
                m_grant = '0;
                m_txd   = IDLE_D;
                m_txc   = 8'hFF;
                m_busy  = 1'b0;
                m_abort = 1'b0;
            end else begin
                m_abort = 1'b0;
                m_kill  = 1'b0;
                case (m_state)
                    M_IDLE: begin
                        m_txd   = IDLE_D;
                        m_txc   = 8'hFF;
                        m_found = 1'b0;
                        if (link_up) begin
                            for (int k = 0; k < N_REQ; k++) begin
                                m_idx = (m_ptr + k) % N_REQ;
                                if (!m_found && req[m_idx] && !m_mask[m_idx]) begin
                                    m_found = 1'b1;
                                    m_cur   = m_idx;
                                end
                            end
                        end
                        if (m_found) begin
                            m_grant = 2'b01 << m_cur;
                            m_busy  = 1'b1;
                            m_ptr   = (m_cur + 1) % N_REQ;
                            m_fcnt  = 0;
                            m_state = M_GRANT;
                        end
                    end
                    M_GRANT: begin
                        if (!req[m_cur]) begin
                            m_grant = '0;
                            m_busy  = 1'b0;
                            m_txd   = IDLE_D;
                            m_txc   = 8'hFF;
                            m_gcnt  = IFG_CYCLES - 1;
                            m_state = M_GAP;
                        end else if (m_fcnt == MAX_FRAME_CYCLES - 1 || !link_up) begin
                            m_grant = '0;
                            m_busy  = 1'b0;
                            m_txd   = ERR_D;
                            m_txc   = 8'hFF;
                            m_abort = 1'b1;
                            m_kill  = 1'b1;
                            m_gcnt  = IFG_CYCLES - 1;
                            m_state = M_GAP;
                        end else begin
                            m_txd  = src_txd[64*m_cur +: 64];
                            m_txc  = src_txc[8*m_cur +: 8];
                            m_fcnt = m_fcnt + 1;
                        end
                    end
                    default: begin
                        m_txd = IDLE_D;
                        m_txc = 8'hFF;
                        if (m_gcnt == 0) m_state = M_IDLE;
                        else             m_gcnt  = m_gcnt - 1;
                    end
                endcase
                m_mask = m_mask & req;
                if (m_kill) m_mask[m_cur] = 1'b1;
            end
            sb.push_back(obs_t'({m_grant, m_busy, m_abort, m_txc, m_txd}));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic randomize_src();
        src_txd = {$urandom, $urandom, $urandom, $urandom};
        src_txc = 16'($urandom);
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        req     = 2'b00;
        link_up = 1'b1;
        repeat (2) @(negedge xgmii_clk);
        sys_rst = 1'b0;
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    // Scenario: reset values, then idle with no requests
    // ------------------------------------------------------------------
    task automatic test_reset();
        sys_rst = 1'b1;
        req     = 2'b00;
        link_up = 1'b1;
        randomize_src();
        for (int k = 1; k <= 6; k++) begin
            @(negedge xgmii_clk);
            total_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL reset_sb cycle %0d: no expected column queued", k);
            end else begin
                exp_o = sb.pop_front();
                if (obs !== exp_o) $display("[TB] FAIL reset_sb cycle %0d: got %h want %h", k, obs, exp_o);
                else passed_checks++;
            end
            total_checks++;
            if (obs !== {2'b00, 1'b0, 1'b0, 8'hFF, IDLE_D})
                $display("[TB] FAIL reset_idle cycle %0d: got %h want %h", k, obs, {2'b00, 1'b0, 1'b0, 8'hFF, IDLE_D});
            else passed_checks++;
            randomize_src();
            if (k == 3) sys_rst = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Scenario: one 10-cycle frame from source 0, then source 1 after gap
    // ------------------------------------------------------------------
    task automatic test_single_frame();
        logic [63:0] first_col;
        apply_reset();
        req = 2'b01;
        randomize_src();
        first_col = '0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge xgmii_clk);
            total_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL single_sb cycle %0d: no expected column queued", k);
            end else begin
                exp_o = sb.pop_front();
                if (obs !== exp_o) $display("[TB] FAIL single_sb cycle %0d: got %h want %h", k, obs, exp_o);
                else passed_checks++;
            end
            if (k == 1) begin
                total_checks++;
                if (grant !== 2'b01) $display("[TB] FAIL single_grant: got %b want 01", grant);
                else passed_checks++;
            end
            if (k == 2) begin
                total_checks++;
                if (xgmii_txd !== first_col) $display("[TB] FAIL single_first_col: got %h want %h", xgmii_txd, first_col);
                else passed_checks++;
            end
            if (k >= 11 && k <= 13) begin
                total_checks++;
                if (grant !== 2'b00) $display("[TB] FAIL single_gap cycle %0d: got %b want 00", k, grant);
                else passed_checks++;
            end
            if (k == 14) begin
                total_checks++;
                if (grant !== 2'b10) $display("[TB] FAIL single_next_grant: got %b want 10", grant);
                else passed_checks++;
            end
            randomize_src();
            if (k == 1) first_col = src_txd[63:0];
            req[0] = (k <= 9);
            req[1] = (k >= 11 && k <= 16);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenario: both sources requesting continuously, short frames
    // ------------------------------------------------------------------
    task automatic test_round_robin();
        int         cnt [2];
        logic [1:0] prev;
        logic [1:0] seen[$];
        logic [1:0] want [4];
        want[0] = 2'b01;
        want[1] = 2'b10;
        want[2] = 2'b01;
        want[3] = 2'b10;
        apply_reset();
        req = 2'b11;
        randomize_src();
        prev   = '0;
        cnt[0] = 0;
        cnt[1] = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge xgmii_clk);
            total_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL rr_sb cycle %0d: no expected column queued", k);
            end else begin
                exp_o = sb.pop_front();
                if (obs !== exp_o) $display("[TB] FAIL rr_sb cycle %0d: got %h want %h", k, obs, exp_o);
                else passed_checks++;
            end
            if (grant !== 2'b00 && prev === 2'b00) seen.push_back(grant);
            prev = grant;
            randomize_src();
            for (int i = 0; i < 2; i++) begin
                if (!req[i]) begin
                    req[i] = 1'b1;
                end else if (m_grant[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 4) begin
                        req[i] = 1'b0;
                        cnt[i] = 0;
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            total_checks++;
            if (j >= seen.size()) $display("[TB] FAIL rr_order %0d: got no grant want %b", j, want[j]);
            else if (seen[j] !== want[j]) $display("[TB] FAIL rr_order %0d: got %b want %b", j, seen[j], want[j]);
            else passed_checks++;
        end
        req = 2'b00;
    endtask

    // ------------------------------------------------------------------
    // Scenario: source 1 holds its request past the frame limit
    // ------------------------------------------------------------------
    task automatic test_watchdog();
        int   aborts, errs, g1_rises;
        logic prev1;
        apply_reset();
        req = 2'b10;
        randomize_src();
        aborts   = 0;
        errs     = 0;
        g1_rises = 0;
        prev1    = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            @(negedge xgmii_clk);
            total_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL wd_sb cycle %0d: no expected column queued", k);
            end else begin
                exp_o = sb.pop_front();
                if (obs !== exp_o) $display("[TB] FAIL wd_sb cycle %0d: got %h want %h", k, obs, exp_o);
                else passed_checks++;
            end
            if (abort === 1'b1) aborts++;
            if (xgmii_txd === ERR_D && xgmii_txc === 8'hFF) errs++;
            if (grant[1] === 1'b1 && prev1 === 1'b0) g1_rises++;
            prev1 = grant[1];
            if (k == 17) begin
                total_checks++;
                if ({abort, grant, xgmii_txd} !== {1'b1, 2'b00, ERR_D})
                    $display("[TB] FAIL wd_abort_col: got %b %b %h want 1 00 %h", abort, grant, xgmii_txd, ERR_D);
                else passed_checks++;
            end
            if (k == 20) begin
                total_checks++;
                if (grant !== 2'b01) $display("[TB] FAIL wd_other_served: got %b want 01", grant);
                else passed_checks++;
            end
            if (k == 43) begin
                total_checks++;
                if (grant !== 2'b10) $display("[TB] FAIL wd_regrant: got %b want 10", grant);
                else passed_checks++;
            end
            randomize_src();
            req[1] = (k <= 39) || (k >= 42 && k <= 45);
            req[0] = (k >= 3 && k <= 22);
        end
        total_checks++;
        if (aborts != 1) $display("[TB] FAIL wd_abort_count: got %0d want 1", aborts);
        else passed_checks++;
        total_checks++;
        if (errs != 1) $display("[TB] FAIL wd_err_count: got %0d want 1", errs);
        else passed_checks++;
        total_checks++;
        if (g1_rises != 2) $display("[TB] FAIL wd_src1_grants: got %0d want 2", g1_rises);
        else passed_checks++;
    endtask

    // ------------------------------------------------------------------
    // Scenario: link drops in the middle of a frame
    // ------------------------------------------------------------------
    task automatic test_link_down();
        int viol;
        apply_reset();
        req = 2'b11;
        randomize_src();
        viol = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge xgmii_clk);
            total_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL link_sb cycle %0d: no expected column queued", k);
            end else begin
                exp_o = sb.pop_front();
                if (obs !== exp_o) $display("[TB] FAIL link_sb cycle %0d: got %h want %h", k, obs, exp_o);
                else passed_checks++;
            end
            if (k == 6) begin
                total_checks++;
                if ({abort, xgmii_txd} !== {1'b1, ERR_D})
                    $display("[TB] FAIL link_abort_col: got %b %h want 1 %h", abort, xgmii_txd, ERR_D);
                else passed_checks++;
            end
            if (k >= 7 && k <= 20 && grant !== 2'b00) viol++;
            if (k == 21) begin
                total_checks++;
                if (grant !== 2'b10) $display("[TB] FAIL link_regrant: got %b want 10", grant);
                else passed_checks++;
            end
            randomize_src();
            link_up = !(k >= 5 && k <= 19);
            req     = (k <= 23) ? 2'b11 : 2'b00;
        end
        total_checks++;
        if (viol != 0) $display("[TB] FAIL link_no_grant: got %0d granted cycles want 0", viol);
        else passed_checks++;
    endtask

    // ------------------------------------------------------------------
    // Scenario: reset asserted while a frame is in flight
    // ------------------------------------------------------------------
    task automatic test_reset_mid_frame();
        apply_reset();
        req = 2'b01;
        randomize_src();
        for (int k = 1; k <= 14; k++) begin
            @(negedge xgmii_clk);
            total_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL rst_sb cycle %0d: no expected column queued", k);
            end else begin
                exp_o = sb.pop_front();
                if (obs !== exp_o) $display("[TB] FAIL rst_sb cycle %0d: got %h want %h", k, obs, exp_o);
                else passed_checks++;
            end
            if (k == 5) begin
                total_checks++;
                if (obs !== {2'b00, 1'b0, 1'b0, 8'hFF, IDLE_D})
                    $display("[TB] FAIL rst_outputs: got %h want %h", obs, {2'b00, 1'b0, 1'b0, 8'hFF, IDLE_D});
                else passed_checks++;
            end
            if (k == 6) begin
                total_checks++;
                if (grant !== 2'b01) $display("[TB] FAIL rst_ptr_zero: got %b want 01", grant);
                else passed_checks++;
            end
            randomize_src();
            sys_rst = (k == 4);
            if (k < 3)       req = 2'b01;
            else if (k <= 8) req = 2'b11;
            else             req = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_watchdog();
        test_link_down();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
